spdif_sample_feeder: RTL and testbench

Upstream stage of the S/PDIF frame encoder. It accepts stereo sample pairs on a valid/ready stream and buffers them in a small FIFO. It serialises each pair into left-then-right sub-frame requests and attaches the channel-status (C) bit and the user (U) bit for each sub-frame. The C bit is chosen from a 40-bit channel-status word using the encoder's `sub_frame_number`. The block runs entirely in the `clk128` domain, and its outputs connect directly to the encoder's `i_*` inputs.

---
 rtl/spdif_sample_feeder.sv | 160 ++++++++++++++++
 tb/tb_spdif_sample_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_sample_feeder.sv
// Stereo sample-pair FIFO and left/right sub-frame serialiser feeding the S/PDIF encoder.
// Optional per-sample U bits are enabled with `define SPDIF_FEEDER_USER_EN.
module spdif_sample_feeder #(
   parameter int DEPTH = 4
) (
   input  logic                     clk128,
   input  logic                     reset_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [23:0]              s_left,
   input  logic [23:0]              s_right,
`ifdef SPDIF_FEEDER_USER_EN
   input  logic [1:0]               s_user,
`endif
   input  logic [39:0]              cs_bits,
   input  logic [8:0]               sub_frame_number,
   output logic                     o_valid,
   input  logic                     o_ready,
   output logic                     o_is_left,
   output logic [23:0]              o_audio,
   output logic                     o_user,
   output logic                     o_control,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
`ifdef SPDIF_FEEDER_USER_EN
   localparam int EW = 50;
`else
   localparam int EW = 48;
`endif
   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

   // state | meaning
   // ST_EMPTY | OPR holds no pair (full=0)
   // ST_LEFT  | OPR full, presenting left sub-frame (phase=0)
   // ST_RIGHT | OPR full, presenting right sub-frame (phase=1)
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [EW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [EW-1:0]   wr_data, rd_data;
   logic            push, pop, xfer, fifo_empty, phase;
   logic [23:0]     pair_left, pair_right;
   logic [39:0]     cs_shadow;
   logic [7:0]      frame_idx;
`ifdef SPDIF_FEEDER_USER_EN
   logic [1:0]      pair_user;
`endif

   assign s_ready    = (level != LEVEL_FULL);
   assign push       = s_valid && s_ready;
   assign fifo_empty = (level == '0);
   assign xfer       = o_valid && o_ready;

`ifdef SPDIF_FEEDER_USER_EN
   assign wr_data = {s_user, s_left, s_right};
`else
   assign wr_data = {s_left, s_right};
`endif
   assign rd_data = mem[rd_ptr];

   // Storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge clk128) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk128) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk128) begin
      if (!reset_n) state <= ST_EMPTY;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = ST_LEFT;
            end
         end
         ST_LEFT: begin
            if (xfer) state_nxt = ST_RIGHT;
         end
         ST_RIGHT: begin
            // Transfers are final even if the encoder rejected the phase.
            if (xfer) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = ST_LEFT;
               end else begin
                  state_nxt = ST_EMPTY;
               end
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk128) begin
      if (!reset_n) begin
         pair_left  <= '0;
         pair_right <= '0;
`ifdef SPDIF_FEEDER_USER_EN
         pair_user  <= '0;
`endif
      end else if (pop) begin
         pair_left  <= rd_data[47:24];
         pair_right <= rd_data[23:0];
`ifdef SPDIF_FEEDER_USER_EN
         pair_user  <= rd_data[49:48];
`endif
      end
   end

   assign phase     = (state == ST_RIGHT);
   assign o_valid   = (state != ST_EMPTY);
   assign o_is_left = !phase;
   assign o_audio   = phase ? pair_right : pair_left;
`ifdef SPDIF_FEEDER_USER_EN
   assign o_user    = pair_user[phase];
`else
   assign o_user    = 1'b0;
`endif

   // New channel-status words only take effect at a block boundary or while idle.
   always_ff @(posedge clk128) begin
      if (!reset_n)
         cs_shadow <= '0;
      else if (sub_frame_number == 9'd383 || state == ST_EMPTY)
         cs_shadow <= cs_bits;
   end

   assign frame_idx = sub_frame_number[8:1];
   assign o_control = (frame_idx < 8'd40) ? cs_shadow[frame_idx[5:0]] : 1'b0;

endmodule

// File: tb/tb_spdif_sample_feeder.sv
// Directed bench for spdif_sample_feeder (default build, DEPTH=4): C-bit vector table
// plus hand-written sequences for streaming, stalls, block-boundary loads and reset.
module tb_spdif_sample_feeder;

   logic        clk128 = 1'b0;
   logic        reset_n;
   logic        s_valid;
   logic        s_ready;
   logic [23:0] s_left, s_right;
   logic [39:0] cs_bits;
   logic [8:0]  sub_frame_number;
   logic        o_valid, o_ready, o_is_left, o_user, o_control;
   logic [23:0] o_audio;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [39:0] cs;
      logic [8:0]  sfn;
      logic        exp;
   } cvec_t;

   cvec_t vec[12];

   spdif_sample_feeder #(.DEPTH(4)) dut (
      .clk128(clk128), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_left(s_left), .s_right(s_right), .cs_bits(cs_bits),
      .sub_frame_number(sub_frame_number), .o_valid(o_valid), .o_ready(o_ready),
      .o_is_left(o_is_left), .o_audio(o_audio), .o_user(o_user),
      .o_control(o_control), .level(level)
   );

   always #5 clk128 = ~clk128;

   task automatic tick();
      @(posedge clk128);
      #1;
   endtask

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] lval(input int i);
      return 24'h100000 + 24'(i);
   endfunction

   function automatic logic [23:0] rval(input int i);
      return 24'h200000 + 24'(i);
   endfunction

   initial begin
      logic [39:0] cs_m;
      logic [7:0]  f;
      logic        e;

      vec[0]  = '{40'h00_0000_0005, 9'd0,   1'b1};
      vec[1]  = '{40'h00_0000_0005, 9'd1,   1'b1};
      vec[2]  = '{40'h00_0000_0005, 9'd2,   1'b0};
      vec[3]  = '{40'h00_0000_0005, 9'd4,   1'b1};
      vec[4]  = '{40'h00_0000_0005, 9'd5,   1'b1};
      vec[5]  = '{40'h00_0000_0005, 9'd6,   1'b0};
      vec[6]  = '{40'hFF_FFFF_FFFF, 9'd79,  1'b1};
      vec[7]  = '{40'hFF_FFFF_FFFF, 9'd80,  1'b0};
      vec[8]  = '{40'hFF_FFFF_FFFF, 9'd383, 1'b0};
      vec[9]  = '{40'h80_0000_0000, 9'd78,  1'b1};
      vec[10] = '{40'h80_0000_0000, 9'd76,  1'b0};
      vec[11] = '{40'h00_0000_0000, 9'd0,   1'b0};

      reset_n = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
      cs_bits = 40'h5; sub_frame_number = 9'd0; o_ready = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      chk("rst_level",   48'(level), 48'd0);
      chk("rst_valid",   48'(o_valid), 48'd0);
      chk("rst_is_left", 48'(o_is_left), 48'd1);
      chk("rst_audio",   48'(o_audio), 48'd0);
      chk("rst_user",    48'(o_user), 48'd0);
      chk("rst_control", 48'(o_control), 48'd0);
      chk("rst_s_ready", 48'(s_ready), 48'd1);

      // C-bit table; shadow follows cs_bits while idle
      for (int i = 0; i < 12; i++) begin
         cs_bits = vec[i].cs;
         tick();
         sub_frame_number = vec[i].sfn;
         #1;
         chk($sformatf("cbit_vec%0d", i), 48'(o_control), 48'(vec[i].exp));
      end

      // full sweep of sub-frame numbers
      cs_m = 40'h00_0000_0005;
      cs_bits = cs_m;
      tick();
      for (int s = 0; s < 384; s++) begin
         sub_frame_number = 9'(s);
         #1;
         f = 8'(s >> 1);
         e = (f < 8'd40) ? cs_m[f[5:0]] : 1'b0;
         chk($sformatf("cbit_sweep%0d", s), 48'(o_control), 48'(e));
      end
      sub_frame_number = 9'd0;

      // basic pair
      o_ready = 1'b1;
      s_valid = 1'b1; s_left = 24'h123456; s_right = 24'hABCDEF;
      tick();
      s_valid = 1'b0;
      chk("basic_valid_n1", 48'(o_valid), 48'd0);
      chk("basic_level_n1", 48'(level), 48'd1);
      tick();
      chk("basic_valid_l", 48'(o_valid), 48'd1);
      chk("basic_isleft_l", 48'(o_is_left), 48'd1);
      chk("basic_audio_l", 48'(o_audio), 48'h123456);
      chk("basic_level_l", 48'(level), 48'd0);
      tick();
      chk("basic_valid_r", 48'(o_valid), 48'd1);
      chk("basic_isleft_r", 48'(o_is_left), 48'd0);
      chk("basic_audio_r", 48'(o_audio), 48'hABCDEF);
      tick();
      chk("basic_valid_end", 48'(o_valid), 48'd0);
      chk("basic_level_end", 48'(level), 48'd0);

      // fill and stall: pair0 moves into the OPR, pairs 1..4 fill the FIFO
      o_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1; s_left = lval(i); s_right = rval(i);
         chk($sformatf("fill_ready%0d", i), 48'(s_ready), 48'd1);
         tick();
      end
      s_left = lval(5); s_right = rval(5);
      chk("fill_ready_full", 48'(s_ready), 48'd0);
      chk("fill_level_full", 48'(level), 48'd4);
      tick();
      s_valid = 1'b0;
      chk("fill_level_hold", 48'(level), 48'd4);
      chk("stall_isleft", 48'(o_is_left), 48'd1);
      chk("stall_audio", 48'(o_audio), 48'(lval(0)));
      o_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("drain_valid%0d", k), 48'(o_valid), 48'd1);
         chk($sformatf("drain_isleft%0d", k), 48'(o_is_left), 48'((k % 2) == 0));
         chk($sformatf("drain_audio%0d", k), 48'(o_audio),
             48'(((k % 2) == 0) ? lval(k / 2) : rval(k / 2)));
         tick();
      end
      chk("drain_valid_end", 48'(o_valid), 48'd0);
      chk("drain_level_end", 48'(level), 48'd0);

      // block-boundary C load while a request is pending
      cs_bits = 40'h5;
      o_ready = 1'b0;
      s_valid = 1'b1; s_left = 24'h3C3C3C; s_right = 24'hC3C3C3;
      tick();
      s_valid = 1'b0;
      tick();
      chk("blk_pending", 48'(o_valid), 48'd1);
      cs_bits = 40'hA;
      sub_frame_number = 9'd100;
      tick();
      sub_frame_number = 9'd0; #1;
      chk("blk_old_f0", 48'(o_control), 48'd1);
      sub_frame_number = 9'd2; #1;
      chk("blk_old_f1", 48'(o_control), 48'd0);
      sub_frame_number = 9'd4; #1;
      chk("blk_old_f2", 48'(o_control), 48'd1);
      sub_frame_number = 9'd383;
      tick();
      sub_frame_number = 9'd0; #1;
      chk("blk_new_f0", 48'(o_control), 48'd0);
      sub_frame_number = 9'd2; #1;
      chk("blk_new_f1", 48'(o_control), 48'd1);
      sub_frame_number = 9'd4; #1;
      chk("blk_new_f2", 48'(o_control), 48'd0);
      sub_frame_number = 9'd6; #1;
      chk("blk_new_f3", 48'(o_control), 48'd1);

      // stray right: encoder resynchronised, feeder still advances
      sub_frame_number = 9'd1;
      o_ready = 1'b1;
      s_valid = 1'b1; s_left = 24'h5A5A5A; s_right = 24'hA5A5A5;
      tick();
      s_valid = 1'b0;
      chk("stray_isleft_r", 48'(o_is_left), 48'd0);
      chk("stray_audio_r", 48'(o_audio), 48'hC3C3C3);
      sub_frame_number = 9'd0;
      tick();
      chk("stray_valid_next", 48'(o_valid), 48'd1);
      chk("stray_isleft_next", 48'(o_is_left), 48'd1);
      chk("stray_audio_next", 48'(o_audio), 48'h5A5A5A);
      chk("stray_level_next", 48'(level), 48'd0);
      tick(); tick();
      chk("stray_drained", 48'(o_valid), 48'd0);

      // mid-stream reset with three pairs queued
      o_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_left = lval(10 + i); s_right = rval(10 + i);
         tick();
      end
      s_valid = 1'b0;
      chk("mrst_level_pre", 48'(level), 48'd3);
      sub_frame_number = 9'd2; #1;
      chk("mrst_control_pre", 48'(o_control), 48'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mrst_level", 48'(level), 48'd0);
      chk("mrst_valid", 48'(o_valid), 48'd0);
      chk("mrst_s_ready", 48'(s_ready), 48'd1);
      chk("mrst_control", 48'(o_control), 48'd0);
      chk("mrst_is_left", 48'(o_is_left), 48'd1);

      // stream restarts cleanly with no stale pair
      o_ready = 1'b1;
      s_valid = 1'b1; s_left = 24'h0F0F0F; s_right = 24'hF0F0F0;
      tick();
      s_valid = 1'b0;
      chk("recov_valid_n1", 48'(o_valid), 48'd0);
      tick();
      chk("recov_audio_l", 48'(o_audio), 48'h0F0F0F);
      tick();
      chk("recov_audio_r", 48'(o_audio), 48'hF0F0F0);
      tick();
      chk("recov_idle", 48'(o_valid), 48'd0);
      chk("recov_level", 48'(level), 48'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
